uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 126 ++++++++++++
 tb/tb_uart_tx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity bit, one stop bit.
// Every output is a flop, so tx, busy and done carry no combinational path from the inputs.
module uart_tx #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY       = 0
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned IdxW = $clog2(DATA_BITS + 1);

  // Both counters count down to zero and are reloaded at each bit boundary.
  localparam logic [CntW-1:0] CntLoad = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxLoad = IdxW'(DATA_BITS - 1);
  localparam bit              ParEn   = (PARITY != 0);
  localparam bit              ParOdd  = (PARITY == 2);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e               state_q;
  logic [CntW-1:0]      cnt_q;
  logic [IdxW-1:0]      idx_q;
  logic [DATA_BITS-1:0] shreg_q;
  // Running XOR of the bits already shifted out; equals the word parity once DATA is done.
  logic                 par_q;

  // Frame sequencer with registered tx/busy/done.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StStart;
            shreg_q <= data;
            par_q   <= 1'b0;
            cnt_q   <= CntLoad;
            tx      <= 1'b0;
            busy    <= 1'b1;
          end
        end
        StStart: begin
          if (cnt_q == '0) begin
            state_q <= StData;
            tx      <= shreg_q[0];
            par_q   <= shreg_q[0];
            shreg_q <= shreg_q >> 1;
            idx_q   <= IdxLoad;
            cnt_q   <= CntLoad;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StData: begin
          if (cnt_q == '0) begin
            cnt_q <= CntLoad;
            if (idx_q == '0) begin
              if (ParEn) begin
                state_q <= StParity;
                tx      <= par_q ^ ParOdd;
              end else begin
                state_q <= StStop;
                tx      <= 1'b1;
              end
            end else begin
              tx      <= shreg_q[0];
              par_q   <= par_q ^ shreg_q[0];
              shreg_q <= shreg_q >> 1;
              idx_q   <= idx_q - 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StParity: begin
          if (cnt_q == '0) begin
            state_q <= StStop;
            tx      <= 1'b1;
            cnt_q   <= CntLoad;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StStop: begin
          if (cnt_q == '0) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b1;
            tx      <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          tx      <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (no parity, even, odd, 5-bit at one clock per bit).
// One instance is selected at a time; a monitor checks every line cycle of each frame
// against words queued by the stimulus.
module tb_uart_tx;

  logic        clk;
  logic        clear;
  logic        start;
  logic [15:0] din;
  int          sel;
  int          nbits;
  int          cpb;
  int          pmode;

  logic [3:0] tx_v, busy_v, done_v;
  logic       mon_tx, mon_busy, mon_done;

  int n_checks = 0;
  int n_errors = 0;
  int last_gap = 0;
  logic [15:0] sb[$];

  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(0)) u_none (
    .clk(clk), .clear(clear), .start(start && sel == 0), .data(din[7:0]),
    .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(1)) u_even (
    .clk(clk), .clear(clear), .start(start && sel == 1), .data(din[7:0]),
    .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(2)) u_odd (
    .clk(clk), .clear(clear), .start(start && sel == 2), .data(din[7:0]),
    .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));
  uart_tx #(.DATA_BITS(5), .CLKS_PER_BIT(1), .PARITY(0)) u_fast (
    .clk(clk), .clear(clear), .start(start && sel == 3), .data(din[4:0]),
    .tx(tx_v[3]), .busy(busy_v[3]), .done(done_v[3]));

  // Route the selected instance to the monitor.
  always_comb begin
    mon_tx   = tx_v[sel[1:0]];
    mon_busy = busy_v[sel[1:0]];
    mon_done = done_v[sel[1:0]];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic select(input int s, input int nb, input int c, input int p);
    sel   = s;
    nbits = nb;
    cpb   = c;
    pmode = p;
  endtask

  // One-cycle start pulse; the accepted word is queued for the monitor.
  task automatic send(input logic [15:0] w);
    logic [15:0] m;
    m = (16'h1 << nbits) - 16'h1;
    @(negedge clk);
    din   = w;
    start = 1'b1;
    sb.push_back(w & m);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Checks n frames cycle by cycle, starting the search at the current negedge.
  task automatic watch(input int n);
    int          t;
    int          nb;
    logic [15:0] w;
    logic        eb;
    for (int k = 0; k < n; k++) begin
      t = 0;
      while (mon_tx === 1'b1 && t < 300) begin
        @(negedge clk);
        t++;
      end
      last_gap = t;
      if (t >= 300) begin
        check_eq("frame_timeout", 1, 0);
        return;
      end
      if (sb.size() == 0) begin
        check_eq("unexpected_frame", 1, 0);
        return;
      end
      w  = sb.pop_front();
      nb = 2 + nbits + ((pmode != 0) ? 1 : 0);
      for (int b = 0; b < nb; b++) begin
        if (b == 0) eb = 1'b0;
        else if (b <= nbits) eb = w[b-1];
        else if (pmode != 0 && b == nbits + 1) eb = (^w) ^ (pmode == 2);
        else eb = 1'b1;
        for (int c = 0; c < cpb; c++) begin
          check_eq($sformatf("tx s%0d w%0h bit%0d cyc%0d", sel, w, b, c), int'(mon_tx), int'(eb));
          check_eq($sformatf("busy s%0d bit%0d", sel, b), int'(mon_busy), 1);
          check_eq($sformatf("done_early s%0d bit%0d", sel, b), int'(mon_done), 0);
          @(negedge clk);
        end
      end
      check_eq("done_pulse", int'(mon_done), 1);
      check_eq("busy_after", int'(mon_busy), 0);
      check_eq("tx_after", int'(mon_tx), 1);
    end
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (mon_busy !== 1'b0 || mon_tx !== 1'b1 || mon_done !== 1'b0) seen++;
    end
    check_eq(tag, seen, 0);
  endtask

  initial begin
    clear = 1'b0;
    start = 1'b0;
    din   = '0;
    select(0, 8, 4, 0);
    repeat (3) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      check_eq($sformatf("rst_tx s%0d", s), int'(mon_tx), 1);
      check_eq($sformatf("rst_busy s%0d", s), int'(mon_busy), 0);
      check_eq($sformatf("rst_done s%0d", s), int'(mon_done), 0);
    end
    sel = 0;
    @(negedge clk);
    clear = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frames, no parity.
    select(0, 8, 4, 0);
    fork
      watch(4);
      begin
        send(16'h00A5);
        repeat (45) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
          send(16'($urandom_range(0, 255)));
          repeat (45) @(negedge clk);
        end
      end
    join
    check_eq("sb_empty_basic", sb.size(), 0);

    // start held high: 00 then FF, back to back with one idle cycle; data changes mid-frame.
    fork
      watch(2);
      begin
        @(negedge clk);
        din   = 16'h0000;
        start = 1'b1;
        sb.push_back(16'h0000);
        repeat (5) @(negedge clk);
        din = 16'h00FF;
        sb.push_back(16'h00FF);
        repeat (42) @(negedge clk);
        start = 1'b0;
      end
    join
    check_eq("b2b_gap", last_gap, 1);
    expect_quiet("b2b_no_third", 50);

    // start during a frame is ignored.
    fork
      watch(1);
      begin
        send(16'h0081);
        repeat (8) @(negedge clk);
        din   = 16'h003C;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        din   = 16'h00FF;
      end
    join
    expect_quiet("busy_start_ignored", 60);
    check_eq("sb_empty_ignore", sb.size(), 0);

    // Parity: even then odd on 8'h07, plus one random word each.
    for (int p = 1; p <= 2; p++) begin
      select(p, 8, 4, p);
      fork
        watch(2);
        begin
          send(16'h0007);
          repeat (48) @(negedge clk);
          send(16'($urandom_range(0, 255)));
        end
      join
    end

    // One clock per bit, 5 data bits.
    select(3, 5, 1, 0);
    fork
      watch(3);
      begin
        send(16'h0015);
        repeat (10) @(negedge clk);
        send(16'h000A);
        repeat (10) @(negedge clk);
        send(16'($urandom_range(0, 31)));
      end
    join

    // Asynchronous clear during data bit 3, then a start sampled on the first edge after release.
    select(0, 8, 4, 0);
    @(negedge clk);
    din   = 16'h00A5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (17) @(negedge clk);
    check_eq("pre_clear_tx_bit3", int'(mon_tx), 0);
    #2;
    clear = 1'b0;
    #1;
    check_eq("clear_tx", int'(mon_tx), 1);
    check_eq("clear_busy", int'(mon_busy), 0);
    check_eq("clear_done", int'(mon_done), 0);
    din   = 16'h003C;
    start = 1'b1;
    sb.push_back(16'h003C);
    @(negedge clk);
    clear = 1'b1;
    fork
      watch(1);
      begin
        @(negedge clk);
        start = 1'b0;
      end
    join
    expect_quiet("after_clear_quiet", 30);
    check_eq("sb_empty_final", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
